// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and payload types for the ALU decode/issue stage:
// ALU control codes, MIPS op/funct encodings and the issued bundle layout.
package alu_issue_stage_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    // ALU control codes
    localparam logic [3:0] ALUC_ADD = 4'd0;
    localparam logic [3:0] ALUC_SUB = 4'd1;
    localparam logic [3:0] ALUC_AND = 4'd2;
    localparam logic [3:0] ALUC_OR  = 4'd3;
    localparam logic [3:0] ALUC_XOR = 4'd4;
    localparam logic [3:0] ALUC_SLL = 4'd5;
    localparam logic [3:0] ALUC_SRL = 4'd6;
    localparam logic [3:0] ALUC_SRA = 4'd7;
    localparam logic [3:0] ALUC_LUI = 4'd8;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_fields_t;

    typedef struct packed {
        logic [3:0]    opcode;
        logic [DW-1:0] dina;
        logic [DW-1:0] dinb;
        logic [AW-1:0] dest;
        logic          dest_we;
    } issue_bundle_t;

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// 2-read/1-write register file, r0 hardwired to zero.
// ISSUE_WB_BYPASS_EN: forward a same-cycle writeback to the read ports.
module alu_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a_c,
    output logic [DATA_WIDTH-1:0] rd_data_b_c
);

    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREG];

    // Synchronous write; r0 never written so it stays at its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd_data_a_c = '0;
        rd_data_b_c = '0;
        if (rd_addr_a != '0) rd_data_a_c = regs[rd_addr_a];
        if (rd_addr_b != '0) rd_data_b_c = regs[rd_addr_b];
`ifdef ISSUE_WB_BYPASS_EN
        if (wb_en && (wb_addr != '0) && (wb_addr == rd_addr_a)) rd_data_a_c = wb_data;
        if (wb_en && (wb_addr != '0) && (wb_addr == rd_addr_b)) rd_data_b_c = wb_data;
`endif
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the 32-bit ALU: instruction decode plus 2-entry skid buffer.
// Optional ISSUE_WB_BYPASS_EN forwards same-cycle writeback data to operands.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            opcode,
    output logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] dinb,
    output logic [ADDR_WIDTH-1:0] dest,
    output logic                  dest_we,
    output logic                  ill_instr
);

    if (DATA_WIDTH != 32 || ADDR_WIDTH != 5) begin : g_width_check
        $error("alu_issue_stage supports only DATA_WIDTH=32, ADDR_WIDTH=5");
    end

    instr_fields_t f;
    logic [15:0]   imm;
    logic [DW-1:0] rs_data_c;
    logic [DW-1:0] rt_data_c;

    assign f   = instr_fields_t'(instr);
    assign imm = instr[15:0];

    alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_addr_a   (f.rs),
        .rd_addr_b   (f.rt),
        .rd_data_a_c (rs_data_c),
        .rd_data_b_c (rt_data_c)
    );

    issue_bundle_t dec;
    logic          legal;

    // Combinational decode of the presented instruction word
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        if (f.op == OP_RTYPE) begin
            dec.dest = f.rd;
            dec.dina = rs_data_c;
            dec.dinb = rt_data_c;
            legal    = 1'b1;
            case (f.funct)
                FN_ADD, FN_ADDU: dec.opcode = ALUC_ADD;
                FN_SUB, FN_SUBU: dec.opcode = ALUC_SUB;
                FN_AND:          dec.opcode = ALUC_AND;
                FN_OR:           dec.opcode = ALUC_OR;
                FN_XOR:          dec.opcode = ALUC_XOR;
                FN_SLL:  begin dec.opcode = ALUC_SLL; dec.dina = DW'(f.shamt); end
                FN_SRL:  begin dec.opcode = ALUC_SRL; dec.dina = DW'(f.shamt); end
                FN_SRA:  begin dec.opcode = ALUC_SRA; dec.dina = DW'(f.shamt); end
                FN_SLLV: begin dec.opcode = ALUC_SLL; dec.dina = DW'(rs_data_c[4:0]); end
                FN_SRLV: begin dec.opcode = ALUC_SRL; dec.dina = DW'(rs_data_c[4:0]); end
                FN_SRAV: begin dec.opcode = ALUC_SRA; dec.dina = DW'(rs_data_c[4:0]); end
                default: legal = 1'b0;
            endcase
        end else begin
            dec.dest = f.rt;
            dec.dina = rs_data_c;
            legal    = 1'b1;
            case (f.op)
                OP_ADDI, OP_ADDIU: begin dec.opcode = ALUC_ADD; dec.dinb = {{16{imm[15]}}, imm}; end
                OP_ANDI: begin dec.opcode = ALUC_AND; dec.dinb = DW'(imm); end
                OP_ORI:  begin dec.opcode = ALUC_OR;  dec.dinb = DW'(imm); end
                OP_XORI: begin dec.opcode = ALUC_XOR; dec.dinb = DW'(imm); end
                OP_LUI:  begin dec.opcode = ALUC_LUI; dec.dina = '0; dec.dinb = DW'(imm); end
                default: legal = 1'b0;
            endcase
        end
        dec.dest_we = (dec.dest != '0);
        if (!legal) dec = '0;
    end

    issue_bundle_t head_q, head_n, skid_q, skid_n;
    logic          head_valid_q, head_valid_n;
    logic          skid_valid_q, skid_valid_n;
    logic          in_ready_q, in_ready_n;
    logic          ill_q, ill_n;
    logic          push, pop;

    // Skid buffer next state: head is the presented entry, skid holds the second in FIFO order
    always_comb begin
        head_n       = head_q;
        head_valid_n = head_valid_q;
        skid_n       = skid_q;
        skid_valid_n = skid_valid_q;
        push         = in_valid && in_ready_q && legal;
        pop          = head_valid_q && out_ready;
        ill_n        = in_valid && in_ready_q && !legal;
        if (!head_valid_q || pop) begin
            if (skid_valid_q) begin
                head_n       = skid_q;
                head_valid_n = 1'b1;
                skid_valid_n = push;
                if (push) skid_n = dec;
            end else begin
                head_valid_n = push;
                if (push) head_n = dec;
            end
        end else if (push) begin
            skid_n       = dec;
            skid_valid_n = 1'b1;
        end
        in_ready_n = !(head_valid_n && skid_valid_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            ill_q        <= 1'b0;
        end else begin
            head_q       <= head_n;
            head_valid_q <= head_valid_n;
            skid_q       <= skid_n;
            skid_valid_q <= skid_valid_n;
            in_ready_q   <= in_ready_n;
            ill_q        <= ill_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = head_valid_q;
    assign opcode    = head_q.opcode;
    assign dina      = head_q.dina;
    assign dinb      = head_q.dinb;
    assign dest      = head_q.dest;
    assign dest_we   = head_q.dest_we;
    assign ill_instr = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage; issued bundles are checked against a scoreboard queue.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  opcode;
    logic [31:0] dina;
    logic [31:0] dinb;
    logic [4:0]  dest;
    logic        dest_we;
    logic        ill_instr;

    int tests_run = 0;
    int tests_failed = 0;
    issue_bundle_t exp_q[$];

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .dina      (dina),
        .dinb      (dinb),
        .dest      (dest),
        .dest_we   (dest_we),
        .ill_instr (ill_instr)
    );

    always #5 clk = ~clk;

    function automatic issue_bundle_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                         logic [4:0] d, logic we);
        return {op, a, b, d, we};
    endfunction

    // Scoreboard: every consumed bundle must match the oldest expected entry
    always @(negedge clk) begin
        issue_bundle_t got;
        issue_bundle_t exp;
        if (rst_n && out_valid && out_ready) begin
            got = {opcode, dina, dinb, dest, dest_we};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL bundle_unexpected got op=%0d a=%h b=%h d=%0d we=%0b",
                         opcode, dina, dinb, dest, dest_we);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL bundle got op=%0d a=%h b=%h d=%0d we=%0b exp op=%0d a=%h b=%h d=%0d we=%0b",
                             opcode, dina, dinb, dest, dest_we,
                             exp.opcode, exp.dina, exp.dinb, exp.dest, exp.dest_we);
                end
            end
        end
    end

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] iw, input bit push, input issue_bundle_t exp);
        bit ok = 1'b0;
        in_valid = 1'b1;
        instr = iw;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL issue_timeout instr=%h in_ready=%0b required 1", iw, in_ready);
        end else if (push) begin
            exp_q.push_back(exp);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin done = 1'b1; break; end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({out_valid, in_ready, ill_instr} !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_ctrl got v/r/ill=%b%b%b required 010", out_valid, in_ready, ill_instr);
        end
        tests_run++;
        if ({opcode, dina, dinb, dest, dest_we} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data got op=%0d a=%h b=%h d=%0d we=%0b required all 0",
                     opcode, dina, dinb, dest, dest_we);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL post_reset_idle got v/r=%b%b required 01", out_valid, in_ready);
        end
    endtask

    task automatic test_add();
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd3);
        out_ready = 1'b1;
        issue(32'h00221820, 1'b1, mk(ALUC_ADD, 32'd5, 32'd3, 5'd3, 1'b1));
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_latency out_valid=%0b required 1", out_valid);
        end
        wait_drain();
    endtask

    task automatic test_itype();
        issue(32'h2024FFFF, 1'b1, mk(ALUC_ADD, 32'd5, 32'hFFFF_FFFF, 5'd4, 1'b1));
        issue(32'h3424FFFF, 1'b1, mk(ALUC_OR,  32'd5, 32'h0000_FFFF, 5'd4, 1'b1));
        issue(32'h3C051234, 1'b1, mk(ALUC_LUI, 32'd0, 32'h0000_1234, 5'd5, 1'b1));
        issue(32'h30248001, 1'b1, mk(ALUC_AND, 32'd5, 32'h0000_8001, 5'd4, 1'b1));
        issue(32'h38240001, 1'b1, mk(ALUC_XOR, 32'd5, 32'h0000_0001, 5'd4, 1'b1));
        wait_drain();
    endtask

    task automatic test_shift();
        wb_write(5'd7, 32'h25);
        issue(32'h00023103, 1'b1, mk(ALUC_SRA, 32'd4,  32'd3, 5'd6,  1'b1));
        issue(32'h00E24007, 1'b1, mk(ALUC_SRA, 32'd5,  32'd3, 5'd8,  1'b1));
        issue(32'h00224822, 1'b1, mk(ALUC_SUB, 32'd5,  32'd3, 5'd9,  1'b1));
        issue(32'h000257C0, 1'b1, mk(ALUC_SLL, 32'd31, 32'd3, 5'd10, 1'b1));
        issue(32'h00000000, 1'b1, mk(ALUC_SLL, 32'd0,  32'd0, 5'd0,  1'b0));
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [3];
        issue_bundle_t exps [3];
        bit ok = 1'b0;
        seq[0] = 32'h00221820; exps[0] = mk(ALUC_ADD, 32'd5, 32'd3, 5'd3,  1'b1);
        seq[1] = 32'h00224822; exps[1] = mk(ALUC_SUB, 32'd5, 32'd3, 5'd9,  1'b1);
        seq[2] = 32'h00225825; exps[2] = mk(ALUC_OR,  32'd5, 32'd3, 5'd11, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr = seq[i];
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_accept%0d in_ready=%0b required 1", i, in_ready);
            end
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
        end
        instr = seq[2];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if ({in_ready, out_valid, dest} !== {1'b0, 1'b1, 5'd3}) begin
                tests_failed++;
                $display("FAIL b2b_full c=%0d got rdy=%0b v=%0b dest=%0d required rdy=0 v=1 dest=3",
                         c, in_ready, out_valid, dest);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exps[2]);
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL b2b_third_accept in_ready never rose, required 1");
        end
        wait_drain();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        issue(32'h8C220000, 1'b0, '0);
        @(negedge clk);
        tests_run++;
        if ({ill_instr, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL lw_ill got ill/v=%b%b required 10", ill_instr, out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if ({ill_instr, out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL lw_ill_pulse got ill/v=%b%b required 00", ill_instr, out_valid);
        end
        @(posedge clk); #1;
        issue(32'h00200008, 1'b0, '0);
        @(negedge clk);
        tests_run++;
        if ({ill_instr, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL jr_ill got ill/v=%b%b required 10", ill_instr, out_valid);
        end
        @(posedge clk); #1;
        issue(32'h00221820, 1'b1, mk(ALUC_ADD, 32'd5, 32'd3, 5'd3, 1'b1));
        wait_drain();
    endtask

    task automatic test_bypass_and_reset();
        logic [31:0] a_exp;
`ifdef ISSUE_WB_BYPASS_EN
        a_exp = 32'd9;
`else
        a_exp = 32'd5;
`endif
        out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd9;
        issue(32'h00221820, 1'b1, mk(ALUC_ADD, a_exp, 32'd3, 5'd3, 1'b1));
        wb_en = 1'b0;
        issue(32'h00221820, 1'b1, mk(ALUC_ADD, 32'd9, 32'd3, 5'd3, 1'b1));
        wait_drain();
        out_ready = 1'b0;
        issue(32'h00221820, 1'b1, mk(ALUC_ADD, 32'd9, 32'd3, 5'd3, 1'b1));
        issue(32'h00224822, 1'b1, mk(ALUC_SUB, 32'd9, 32'd3, 5'd9, 1'b1));
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({out_valid, in_ready, ill_instr} !== 3'b010) begin
            tests_failed++;
            $display("FAIL midreset got v/r/ill=%b%b%b required 010", out_valid, in_ready, ill_instr);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(32'h00221820, 1'b1, mk(ALUC_ADD, 32'd0, 32'd0, 5'd3, 1'b1));
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_add();
        test_itype();
        test_shift();
        test_back_to_back();
        test_illegal();
        test_bypass_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
